// File: rtl/l2cache_nway_control.sv
// Control FSM for an N-way set-associative L2 cache: hit handling, tree-PLRU
// update, victim selection, write-back, refill and bounded memory retry.
module l2cache_nway_control #(
    parameter int WAYS      = 4,
    parameter int MAX_RETRY = 3,
    localparam int WIDX     = $clog2(WAYS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cpu_cyc,
    input  logic            cpu_stb,
    input  logic            cpu_we,
    output logic            cpu_ack,
    output logic            cpu_err,
    input  logic [WAYS-1:0] hit_vec,
    input  logic [WAYS-1:0] valid_vec,
    input  logic [WAYS-1:0] dirty_vec,
    input  logic [WAYS-2:0] plru_out,
    output logic [WAYS-2:0] plru_in,
    output logic            plru_write,
    output logic [WAYS-1:0] way_write,
    output logic [WAYS-1:0] valid_write,
    output logic [WAYS-1:0] dirty_write,
    output logic            valid_in,
    output logic            dirty_in,
    output logic [WIDX-1:0] victim_way,
    output logic            datainmux_sel,
    output logic            memaddrmux_sel,
    output logic            mem_cyc,
    output logic            mem_stb,
    output logic            mem_we,
    input  logic            mem_ack,
    input  logic            mem_rty
);

    localparam int RCW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {IDLE, WB, WB_GAP, ALLOC, RTY_WAIT, ERR} state_t;

    state_t          state_q, state_d, origin_q, origin_d;
    logic [WIDX-1:0] victim_q, victim_d;
    logic [RCW-1:0]  retry_q, retry_d;

    logic            req;
    logic [WIDX-1:0] hit_idx, inv_idx, plru_way, victim_sel;
    logic            inv_found;
    logic [WAYS-2:0] plru_upd;
    logic [WAYS-1:0] hit_oh, vic_oh;

    assign req        = cpu_cyc & cpu_stb;
    assign victim_way = victim_q;
    assign hit_oh     = {{(WAYS-1){1'b0}}, 1'b1} << hit_idx;
    assign vic_oh     = {{(WAYS-1){1'b0}}, 1'b1} << victim_q;

    // Lowest-index hit and lowest-index invalid way.
    always_comb begin
        hit_idx   = '0;
        inv_idx   = '0;
        inv_found = 1'b0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (hit_vec[i]) hit_idx = WIDX'(i);
            if (!valid_vec[i]) begin
                inv_idx   = WIDX'(i);
                inv_found = 1'b1;
            end
        end
    end

    // Tree walk: at level l the node is (2^l - 1) + (top l bits of the way index).
    always_comb begin
        plru_way = '0;
        plru_upd = plru_out;
        for (int l = 0; l < WIDX; l++) begin
            for (int p = 0; p < (1 << l); p++) begin
                if (int'(plru_way >> (WIDX - l)) == p)
                    plru_way[WIDX-1-l] = plru_out[(1 << l) - 1 + p];
                if (int'(hit_idx >> (WIDX - l)) == p)
                    plru_upd[(1 << l) - 1 + p] = ~hit_idx[WIDX-1-l];
            end
        end
    end

    assign victim_sel = inv_found ? inv_idx : plru_way;

    always_comb begin
        state_d        = state_q;
        origin_d       = origin_q;
        victim_d       = victim_q;
        retry_d        = retry_q;
        cpu_ack        = 1'b0;
        cpu_err        = 1'b0;
        plru_in        = '0;
        plru_write     = 1'b0;
        way_write      = '0;
        valid_write    = '0;
        dirty_write    = '0;
        valid_in       = 1'b0;
        dirty_in       = 1'b0;
        datainmux_sel  = 1'b0;
        memaddrmux_sel = 1'b0;
        mem_cyc        = 1'b0;
        mem_stb        = 1'b0;
        mem_we         = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && |hit_vec) begin
                    cpu_ack    = 1'b1;
                    plru_write = 1'b1;
                    plru_in    = plru_upd;
                    if (cpu_we) begin
                        datainmux_sel = 1'b1;
                        way_write     = hit_oh;
                        valid_write   = hit_oh;
                        dirty_write   = hit_oh;
                        valid_in      = 1'b1;
                        dirty_in      = 1'b1;
                    end
                end else if (req) begin
                    victim_d = victim_sel;
                    state_d  = (valid_vec[victim_sel] & dirty_vec[victim_sel]) ? WB : ALLOC;
                end
            end
            WB: begin
                mem_cyc        = 1'b1;
                mem_stb        = 1'b1;
                mem_we         = 1'b1;
                memaddrmux_sel = 1'b1;
                if (mem_ack) begin
                    state_d = WB_GAP;
                    retry_d = '0;
                end else if (mem_rty) begin
                    if (int'(retry_q) < MAX_RETRY) begin
                        retry_d  = retry_q + RCW'(1);
                        origin_d = WB;
                        state_d  = RTY_WAIT;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            WB_GAP: state_d = ALLOC;
            ALLOC: begin
                mem_cyc = 1'b1;
                mem_stb = 1'b1;
                // Fill data is only valid with mem_ack, so the array write waits for it.
                if (mem_ack) begin
                    way_write   = vic_oh;
                    valid_write = vic_oh;
                    dirty_write = vic_oh;
                    valid_in    = 1'b1;
                    state_d     = IDLE;
                    retry_d     = '0;
                end else if (mem_rty) begin
                    if (int'(retry_q) < MAX_RETRY) begin
                        retry_d  = retry_q + RCW'(1);
                        origin_d = ALLOC;
                        state_d  = RTY_WAIT;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            RTY_WAIT: state_d = origin_q;
            ERR: begin
                cpu_err = 1'b1;
                retry_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            origin_q <= IDLE;
            victim_q <= '0;
            retry_q  <= '0;
        end else begin
            state_q  <= state_d;
            origin_q <= origin_d;
            victim_q <= victim_d;
            retry_q  <= retry_d;
        end
    end

endmodule

// File: tb/tb_l2cache_nway_control.sv
// Directed bench for l2cache_nway_control (WAYS = 4, MAX_RETRY = 3): a vector
// table for IDLE hit behaviour plus hand-written miss/retry/reset sequences.
module tb_l2cache_nway_control;

    logic       clk, rst;
    logic       cpu_cyc, cpu_stb, cpu_we, cpu_ack, cpu_err;
    logic [3:0] hit_vec, valid_vec, dirty_vec;
    logic [2:0] plru_out, plru_in;
    logic       plru_write;
    logic [3:0] way_write, valid_write, dirty_write;
    logic       valid_in, dirty_in;
    logic [1:0] victim_way;
    logic       datainmux_sel, memaddrmux_sel;
    logic       mem_cyc, mem_stb, mem_we, mem_ack, mem_rty;

    int checks = 0;
    int failures = 0;

    l2cache_nway_control #(.WAYS(4), .MAX_RETRY(3)) dut (
        .clk(clk), .rst(rst),
        .cpu_cyc(cpu_cyc), .cpu_stb(cpu_stb), .cpu_we(cpu_we),
        .cpu_ack(cpu_ack), .cpu_err(cpu_err),
        .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec),
        .plru_out(plru_out), .plru_in(plru_in), .plru_write(plru_write),
        .way_write(way_write), .valid_write(valid_write), .dirty_write(dirty_write),
        .valid_in(valid_in), .dirty_in(dirty_in), .victim_way(victim_way),
        .datainmux_sel(datainmux_sel), .memaddrmux_sel(memaddrmux_sel),
        .mem_cyc(mem_cyc), .mem_stb(mem_stb), .mem_we(mem_we),
        .mem_ack(mem_ack), .mem_rty(mem_rty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       cyc, stb, we;
        logic [3:0] hit;
        logic [2:0] plru;
        logic       ack, pw;
        logic [2:0] pin;
        logic [3:0] ww;
        logic       wr;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_req();
        cpu_cyc = 1'b0; cpu_stb = 1'b0; cpu_we = 1'b0; hit_vec = 4'b0000;
    endtask

    task automatic miss(input logic [3:0] v, input logic [3:0] d, input logic [2:0] p);
        cpu_cyc = 1'b1; cpu_stb = 1'b1; cpu_we = 1'b0; hit_vec = 4'b0000;
        valid_vec = v; dirty_vec = d; plru_out = p;
    endtask

    initial begin
        // Bit i of plru_in/plru_out is heap node i (node 0 = root).
        vt[0] = '{1'b1, 1'b1, 1'b0, 4'b0100, 3'b000, 1'b1, 1'b1, 3'b100, 4'b0000, 1'b0};
        vt[1] = '{1'b1, 1'b1, 1'b1, 4'b0010, 3'b000, 1'b1, 1'b1, 3'b001, 4'b0010, 1'b1};
        vt[2] = '{1'b1, 1'b1, 1'b0, 4'b0001, 3'b000, 1'b1, 1'b1, 3'b011, 4'b0000, 1'b0};
        vt[3] = '{1'b1, 1'b1, 1'b0, 4'b0010, 3'b111, 1'b1, 1'b1, 3'b101, 4'b0000, 1'b0};
        vt[4] = '{1'b1, 1'b1, 1'b0, 4'b1000, 3'b111, 1'b1, 1'b1, 3'b010, 4'b0000, 1'b0};
        vt[5] = '{1'b1, 1'b1, 1'b1, 4'b1000, 3'b000, 1'b1, 1'b1, 3'b000, 4'b1000, 1'b1};
        vt[6] = '{1'b0, 1'b1, 1'b0, 4'b0100, 3'b000, 1'b0, 1'b0, 3'b000, 4'b0000, 1'b0};
        vt[7] = '{1'b1, 1'b0, 1'b1, 4'b0100, 3'b000, 1'b0, 1'b0, 3'b000, 4'b0000, 1'b0};

        rst = 1'b1; drop_req();
        valid_vec = 4'b0000; dirty_vec = 4'b0000; plru_out = 3'b000;
        mem_ack = 1'b0; mem_rty = 1'b0;
        tick(); tick();
        rst = 1'b0; #1;
        chk("rst_cpu_ack", cpu_ack, 0);
        chk("rst_cpu_err", cpu_err, 0);
        chk("rst_mem_cyc", mem_cyc, 0);
        chk("rst_victim", victim_way, 0);
        chk("rst_plru_write", plru_write, 0);

        valid_vec = 4'b1111; dirty_vec = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            cpu_cyc = vt[i].cyc; cpu_stb = vt[i].stb; cpu_we = vt[i].we;
            hit_vec = vt[i].hit; plru_out = vt[i].plru;
            #1;
            chk($sformatf("v%0d_cpu_ack", i), cpu_ack, vt[i].ack);
            chk($sformatf("v%0d_plru_write", i), plru_write, vt[i].pw);
            chk($sformatf("v%0d_plru_in", i), plru_in, vt[i].pin);
            chk($sformatf("v%0d_way_write", i), way_write, vt[i].ww);
            chk($sformatf("v%0d_valid_write", i), valid_write, vt[i].ww);
            chk($sformatf("v%0d_dirty_write", i), dirty_write, vt[i].ww);
            chk($sformatf("v%0d_dirty_in", i), dirty_in, vt[i].wr);
            chk($sformatf("v%0d_valid_in", i), valid_in, vt[i].wr);
            chk($sformatf("v%0d_datainmux", i), datainmux_sel, vt[i].wr);
            chk($sformatf("v%0d_mem_cyc", i), mem_cyc, 0);
            tick();
        end
        drop_req();

        // Miss with an invalid way: straight to ALLOC on way 2.
        miss(4'b1011, 4'b0000, 3'b000); #1;
        chk("m3_idle_ack", cpu_ack, 0);
        chk("m3_idle_mem_cyc", mem_cyc, 0);
        tick(); drop_req(); #1;
        chk("m3_victim", victim_way, 2);
        chk("m3_alloc_we", mem_we, 0);
        chk("m3_alloc_addrmux", memaddrmux_sel, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("m3_alloc_cyc", mem_cyc, 1);
            chk("m3_alloc_nowrite", way_write, 0);
        end
        mem_ack = 1'b1; #1;
        chk("m3_fill_ww", way_write, 4'b0100);
        chk("m3_fill_vw", valid_write, 4'b0100);
        chk("m3_fill_dw", dirty_write, 4'b0100);
        chk("m3_fill_vin", valid_in, 1);
        chk("m3_fill_din", dirty_in, 0);
        chk("m3_fill_mux", datainmux_sel, 0);
        tick(); mem_ack = 1'b0;
        cpu_cyc = 1'b1; cpu_stb = 1'b1; hit_vec = 4'b0100; valid_vec = 4'b1111; #1;
        chk("m3_replay_ack", cpu_ack, 1);
        chk("m3_replay_mem_cyc", mem_cyc, 0);
        tick(); drop_req();

        // Dirty PLRU victim: WB, WB_GAP, ALLOC, replay.
        miss(4'b1111, 4'b1000, 3'b101); #1;
        tick(); drop_req(); #1;
        chk("m4_victim", victim_way, 3);
        chk("m4_wb_cyc", mem_cyc, 1);
        chk("m4_wb_we", mem_we, 1);
        chk("m4_wb_addrmux", memaddrmux_sel, 1);
        tick();
        chk("m4_wb_hold_we", mem_we, 1);
        mem_ack = 1'b1; #1;
        chk("m4_wb_nowrite", way_write, 0);
        chk("m4_wb_noack", cpu_ack, 0);
        tick(); mem_ack = 1'b0; #1;
        chk("m4_gap_cyc", mem_cyc, 0);
        chk("m4_gap_stb", mem_stb, 0);
        tick();
        chk("m4_alloc_cyc", mem_cyc, 1);
        chk("m4_alloc_we", mem_we, 0);
        chk("m4_alloc_addrmux", memaddrmux_sel, 0);
        mem_ack = 1'b1; #1;
        chk("m4_fill_ww", way_write, 4'b1000);
        chk("m4_fill_noack", cpu_ack, 0);
        tick(); mem_ack = 1'b0;
        cpu_cyc = 1'b1; cpu_stb = 1'b1; hit_vec = 4'b1000; #1;
        chk("m4_replay_ack", cpu_ack, 1);
        tick(); drop_req();

        // Four retries in ALLOC -> ERR.
        miss(4'b1111, 4'b0000, 3'b000); #1;
        tick(); drop_req(); #1;
        chk("m5_victim", victim_way, 0);
        for (int r = 0; r < 4; r++) begin
            mem_rty = 1'b1; #1;
            chk("m5_alloc_cyc", mem_cyc, 1);
            chk("m5_alloc_nowrite", way_write, 0);
            tick(); mem_rty = 1'b0; #1;
            if (r < 3) begin
                chk("m5_rtyw_cyc", mem_cyc, 0);
                chk("m5_rtyw_err", cpu_err, 0);
                tick();
            end else begin
                chk("m5_err", cpu_err, 1);
                chk("m5_err_ack", cpu_ack, 0);
                chk("m5_err_ww", way_write, 0);
                chk("m5_err_vw", valid_write, 0);
                chk("m5_err_cyc", mem_cyc, 0);
                tick();
                chk("m5_post_err", cpu_err, 0);
                chk("m5_post_cyc", mem_cyc, 0);
            end
        end

        // Retry count restarts after ERR; ack beats a simultaneous rty.
        miss(4'b1111, 4'b0000, 3'b000); #1;
        tick(); drop_req(); #1;
        for (int r = 0; r < 3; r++) begin
            mem_rty = 1'b1;
            tick(); mem_rty = 1'b0; #1;
            chk("m5b_rtyw_cyc", mem_cyc, 0);
            chk("m5b_rtyw_err", cpu_err, 0);
            tick();
        end
        mem_ack = 1'b1; mem_rty = 1'b1; #1;
        chk("m5b_fill_ww", way_write, 4'b0001);
        chk("m5b_fill_err", cpu_err, 0);
        tick(); mem_ack = 1'b0; mem_rty = 1'b0; #1;
        chk("m5b_idle_cyc", mem_cyc, 0);
        chk("m5b_idle_err", cpu_err, 0);

        // Reset in the middle of a write-back.
        miss(4'b1111, 4'b1111, 3'b101); #1;
        tick(); drop_req(); #1;
        chk("m6_wb_we", mem_we, 1);
        chk("m6_wb_victim", victim_way, 3);
        rst = 1'b1;
        tick(); rst = 1'b0; #1;
        chk("m6_rst_cyc", mem_cyc, 0);
        chk("m6_rst_victim", victim_way, 0);
        chk("m6_rst_err", cpu_err, 0);
        tick();
        chk("m6_stays_idle", mem_cyc, 0);
        cpu_cyc = 1'b1; cpu_stb = 1'b1; hit_vec = 4'b0100; plru_out = 3'b000; #1;
        chk("m6_hit_ack", cpu_ack, 1);
        chk("m6_hit_plru", plru_in, 3'b100);
        tick();
        miss(4'b0111, 4'b1111, 3'b000); #1;
        tick(); drop_req(); #1;
        chk("m6_miss_victim", victim_way, 3);
        chk("m6_miss_alloc_cyc", mem_cyc, 1);
        chk("m6_miss_alloc_we", mem_we, 0);
        mem_ack = 1'b1; #1;
        chk("m6_fill_ww", way_write, 4'b1000);
        tick(); mem_ack = 1'b0; #1;
        chk("m6_end_cyc", mem_cyc, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
